lock_reg_arbiter: RTL and testbench
===================================

Name: lock_reg_arbiter

Overview:
- Shares a bank of NREG 16-bit lockable configuration registers between NREQ requesters.
- Each register has a sticky lock bit. Writes to a locked register are rejected unless a debug-authentication FSM has completed a key match.
- scan_mode never bypasses a lock. It forces rejection of all writes and drops debug authorization.
- Sits between bus-side masters (firmware, DMA, debug port) and the protected register file that feeds downstream control logic.

Parameters:
- NREQ, 2, number of requesters (2..4)
- NREG, 8, number of 16-bit registers (power of two)
- AW, 3, register address width (log2 NREG)
- DBG_KEY, 16'hA5C3, debug unlock key
- MAX_FAIL, 3, failed key attempts before permanent lockout
- FAIL_WAIT, 16, cycles of backoff after each failed attempt

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant (one-hot or zero)
- req_op  in  2*NREQ  per-requester op: 00 read, 01 write, 10 lock, 11 reserved
- req_addr  in  AW*NREQ  per-requester register address
- req_wdata  in  16*NREQ  per-requester write data
- rsp_valid  out  NREQ  one-cycle response pulse to the granted requester
- rsp_err  out  1  error flag qualifying rsp_valid
- rsp_rdata  out  16  read data qualifying rsp_valid
- scan_mode  in  1  scan active
- dbg_key_valid  in  1  debug key strobe
- dbg_key  in  16  debug key value
- dbg_unlocked  out  1  debug override active
- dbg_lockout  out  1  permanent lockout flag
- reg_q  out  16*NREG  register contents
- lock_q  out  NREG  lock bits

Behaviour:
- Reset (sync, active-high):
  - reg_q=0, lock_q=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - dbg_unlocked=0, dbg_lockout=0, fail count=0, round-robin pointer=0, auth FSM=IDLE.
  - Reset asserted mid-transaction discards the pending response. No rsp_valid in the cycle after reset.
- Arbitration:
  - Round-robin, at most one grant per cycle.
  - req_ready[i] is combinational from req_valid and the pointer.
  - Transfer happens when req_valid[i] & req_ready[i].
  - After a transfer the pointer moves to i+1 mod NREQ. No transfer: pointer holds.
  - Requesters must hold op/addr/wdata stable while valid and not ready.
- Response:
  - rsp_valid[i] asserts exactly 1 cycle after the transfer, one cycle wide.
  - rsp_err and rsp_rdata are valid only with rsp_valid. Otherwise rsp_err=0 and rsp_rdata=0.
- Read: rsp_rdata = reg[addr], rsp_err=0. Reads are allowed regardless of lock state.
- Write:
  - Allowed when !scan_mode and (!lock_q[addr] or dbg_unlocked). reg updates on the transfer edge, rsp_err=0.
  - Otherwise the register is unchanged and rsp_err=1.
- Lock:
  - Sets lock_q[addr]=1 on the transfer edge, rsp_err=0. Idempotent.
  - Lock bits clear only on reset. No op, debug state or scan clears them.
- Reserved op: no state change, rsp_err=1, rsp_rdata=0.
- Timing of gating inputs: scan_mode is sampled combinationally in the transfer cycle. dbg_unlocked is its registered value in that cycle.
- Auth FSM states: IDLE, UNLOCKED, BACKOFF, LOCKOUT.
  - IDLE, dbg_key_valid and key==DBG_KEY: go to UNLOCKED (dbg_unlocked=1 from next cycle).
  - IDLE, dbg_key_valid and mismatch: fail count +1. If count reaches MAX_FAIL go to LOCKOUT, else go to BACKOFF and load the counter with FAIL_WAIT.
  - BACKOFF: counter decrements each cycle and dbg_key_valid is ignored. Counter 0 returns to IDLE.
  - UNLOCKED: scan_mode=1 returns to IDLE (dbg_unlocked=0 next cycle). dbg_key_valid with key 16'h0000 is an explicit relock and also returns to IDLE. A successful unlock does not clear the fail count.
  - LOCKOUT: terminal until reset. dbg_lockout=1, dbg_unlocked=0.
  - scan_mode in any state blocks unlock attempts. Key strobes are ignored while scan_mode=1.
- Simultaneous events:
  - A lock op and a write to the same address cannot occur in one cycle (single grant).
  - A write in the same cycle as the unlock key strobe still sees dbg_unlocked=0 and is rejected.

Decomposition:
- Package lock_reg_pkg holds:
  - op_e enum (OP_RD, OP_WR, OP_LOCK, OP_RSV)
  - auth_state_e enum
  - default key and width constants
- One sub-module, rr_arbiter: NREQ-wide round-robin grant with a pointer-update input. Generic, reused by other shared resources.
- Auth FSM and register file stay inline.

Test Plan:
- Basic write/read: after reset, req0 writes addr 2 = 16'h1234, then reads addr 2 -> rsp_rdata=16'h1234, rsp_err=0, response 1 cycle after each transfer.
- Lock enforcement: lock addr 2, then write 16'hBEEF -> rsp_err=1, reg_q[2] stays 16'h1234, lock_q[2]=1. A second lock -> rsp_err=0.
- Scan bypass closed: with lock_q[2]=1, dbg_unlocked=1 and scan_mode=1, write 16'hDEAD -> rsp_err=1, register unchanged, dbg_unlocked=0 next cycle.
- Debug unlock: key 16'hA5C3 then write 16'h5555 to locked addr 2 -> accepted. Key 16'h0000 then write -> rsp_err=1.
- Lockout: three wrong keys, each sent after its backoff (strobes during the 16-cycle backoff ignored) -> dbg_lockout=1. Correct key afterwards -> dbg_unlocked stays 0. Reset clears lockout and lock_q.
- Fairness: req0 and req1 held valid for 6 cycles -> grants alternate 0,1,0,1,0,1. Assert reset mid-sequence -> no rsp_valid next cycle, pointer=0.

Source files
------------

// File: rtl/lock_reg_arbiter_pkg.sv
// Shared types and constants for the lockable register arbiter and its
// debug-authentication logic.
package lock_reg_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    OP_RD   = 2'b00,
    OP_WR   = 2'b01,
    OP_LOCK = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    AUTH_IDLE,
    AUTH_UNLOCKED,
    AUTH_BACKOFF,
    AUTH_LOCKOUT
  } auth_state_e;

  localparam logic [DW-1:0] DEF_DBG_KEY = 16'hA5C3;
  localparam logic [DW-1:0] RELOCK_KEY  = 16'h0000;

endpackage

// File: rtl/lock_reg_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter: one grant per cycle, search starts at
// the pointer, pointer moves past the winner when the caller accepts it.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = r_ptr;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
        w_found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_ptr <= '0;
    else if (i_advance && w_found)
      r_ptr <= (o_idx == PW'(N - 1)) ? '0 : o_idx + PW'(1);
  end

endmodule

// File: rtl/lock_reg_arbiter.sv
// Round-robin shared access to a bank of lockable 16-bit registers, with a
// key-based debug override that scan mode always defeats.
module lock_reg_arbiter
  import lock_reg_pkg::*;
#(
  parameter int              NREQ      = 2,
  parameter int              NREG      = 8,
  parameter int              AW        = 3,
  parameter logic [DW-1:0]   DBG_KEY   = DEF_DBG_KEY,
  parameter int              MAX_FAIL  = 3,
  parameter int              FAIL_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [AW*NREQ-1:0]   req_addr,
  input  logic [DW*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 rsp_err,
  output logic [DW-1:0]        rsp_rdata,
  input  logic                 scan_mode,
  input  logic                 dbg_key_valid,
  input  logic [DW-1:0]        dbg_key,
  output logic                 dbg_unlocked,
  output logic                 dbg_lockout,
  output logic [DW*NREG-1:0]   reg_q,
  output logic [NREG-1:0]      lock_q
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int BW = $clog2(FAIL_WAIT + 1);

  logic [NREQ-1:0]           w_grant;
  logic [GW-1:0]             w_gidx;
  logic                      w_xfer;
  op_e                       w_op;
  logic [AW-1:0]             w_addr;
  logic [DW-1:0]             w_wdata;
  logic                      w_wr_ok;

  logic [NREG-1:0][DW-1:0]   r_regs;
  logic [NREG-1:0]           r_lock;
  logic [NREQ-1:0]           r_rsp_valid;
  logic                      r_rsp_err;
  logic [DW-1:0]             r_rsp_rdata;

  auth_state_e               r_state, w_state_nxt;
  logic [FW-1:0]             r_fail, w_fail_nxt;
  logic [BW-1:0]             r_bo, w_bo_nxt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req_valid),
    .i_advance (w_xfer),
    .o_grant   (w_grant),
    .o_idx     (w_gidx)
  );

  // Grants are only ever raised for valid requesters, so any grant is a transfer.
  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;
  assign w_op      = op_e'(req_op[2*int'(w_gidx) +: 2]);
  assign w_addr    = req_addr[AW*int'(w_gidx) +: AW];
  assign w_wdata   = req_wdata[DW*int'(w_gidx) +: DW];
  assign w_wr_ok   = !scan_mode && (!r_lock[w_addr] || (r_state == AUTH_UNLOCKED));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs      <= '0;
      r_lock      <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_grant;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      if (w_xfer) begin
        case (w_op)
          OP_RD:   r_rsp_rdata <= r_regs[w_addr];
          OP_WR: begin
            if (w_wr_ok) r_regs[w_addr] <= w_wdata;
            else         r_rsp_err      <= 1'b1;
          end
          OP_LOCK: r_lock[w_addr] <= 1'b1;
          default: r_rsp_err <= 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= AUTH_IDLE;
      r_fail  <= '0;
      r_bo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fail  <= w_fail_nxt;
      r_bo    <= w_bo_nxt;
    end
  end

  // The fail count survives successful unlocks; only reset forgives it.
  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail;
    w_bo_nxt    = r_bo;
    case (r_state)
      AUTH_IDLE: begin
        if (dbg_key_valid && !scan_mode) begin
          if (dbg_key == DBG_KEY) begin
            w_state_nxt = AUTH_UNLOCKED;
          end else begin
            w_fail_nxt = r_fail + FW'(1);
            if (int'(w_fail_nxt) >= MAX_FAIL) begin
              w_state_nxt = AUTH_LOCKOUT;
            end else begin
              w_state_nxt = AUTH_BACKOFF;
              w_bo_nxt    = BW'(FAIL_WAIT);
            end
          end
        end
      end
      AUTH_UNLOCKED: begin
        if (scan_mode || (dbg_key_valid && dbg_key == RELOCK_KEY))
          w_state_nxt = AUTH_IDLE;
      end
      AUTH_BACKOFF: begin
        if (r_bo == '0) w_state_nxt = AUTH_IDLE;
        else            w_bo_nxt    = r_bo - BW'(1);
      end
      default: w_state_nxt = AUTH_LOCKOUT;
    endcase
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_err      = r_rsp_err;
  assign rsp_rdata    = r_rsp_rdata;
  assign dbg_unlocked = (r_state == AUTH_UNLOCKED);
  assign dbg_lockout  = (r_state == AUTH_LOCKOUT);
  assign reg_q        = r_regs;
  assign lock_q       = r_lock;

endmodule

// File: tb/tb_lock_reg_arbiter.sv
// Directed walk through the register-locking scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural model.
module tb_lock_reg_arbiter;

  localparam int NREQ = 2;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam logic [15:0] KEY = 16'hA5C3;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [AW*NREQ-1:0]  req_addr;
  logic [16*NREQ-1:0]  req_wdata;
  logic [NREQ-1:0]     rsp_valid;
  logic                rsp_err;
  logic [15:0]         rsp_rdata;
  logic                scan_mode;
  logic                dbg_key_valid;
  logic [15:0]         dbg_key;
  logic                dbg_unlocked;
  logic                dbg_lockout;
  logic [16*NREG-1:0]  reg_q;
  logic [NREG-1:0]     lock_q;

  lock_reg_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .scan_mode(scan_mode), .dbg_key_valid(dbg_key_valid), .dbg_key(dbg_key),
    .dbg_unlocked(dbg_unlocked), .dbg_lockout(dbg_lockout),
    .reg_q(reg_q), .lock_q(lock_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: register contents, lock flags, rotation pointer and
  // the debug-auth status expressed as plain flags and counters.
  logic [15:0] m_reg [NREG];
  bit          m_lock [NREG];
  int          m_ptr;
  int          m_fails;
  int          m_wait;      // -1 when no backoff is running
  bit          m_unl;
  bit          m_out;

  logic [NREQ-1:0] last_grant;
  logic [NREQ-1:0] o_rv;
  logic            o_err;
  logic [15:0]     o_rd;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*NREG-1:0] pack_regs();
    logic [16*NREG-1:0] p;
    for (int i = 0; i < NREG; i++) p[16*i +: 16] = m_reg[i];
    return p;
  endfunction

  function automatic logic [NREG-1:0] pack_locks();
    logic [NREG-1:0] p;
    for (int i = 0; i < NREG; i++) p[i] = m_lock[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = 16'h0;
      m_lock[i] = 1'b0;
    end
    m_ptr = 0; m_fails = 0; m_wait = -1; m_unl = 0; m_out = 0;
  endtask

  // One clock: check the combinational grant, advance the model, then check
  // every registered output just after the edge.
  task automatic tick();
    int              g;
    int              a;
    logic [1:0]      op;
    logic [15:0]     d;
    logic [NREQ-1:0] eg, nv;
    bit              ne;
    logic [15:0]     nd;
    #1;
    g = -1; eg = '0;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    if (g >= 0) eg[g] = 1'b1;
    chk("ready", req_ready, eg);
    last_grant = eg;
    nv = '0; ne = 0; nd = 16'h0;
    if (reset) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        op = req_op[2*g +: 2];
        a  = int'(req_addr[AW*g +: AW]);
        d  = req_wdata[16*g +: 16];
        nv[g] = 1'b1;
        case (op)
          2'd0: nd = m_reg[a];
          2'd1: if (!scan_mode && (!m_lock[a] || m_unl)) m_reg[a] = d; else ne = 1;
          2'd2: m_lock[a] = 1'b1;
          default: ne = 1;
        endcase
        m_ptr = (g + 1) % NREQ;
      end
      if (m_out) begin
      end else if (m_wait >= 0) begin
        if (m_wait == 0) m_wait = -1; else m_wait--;
      end else if (m_unl) begin
        if (scan_mode || (dbg_key_valid && dbg_key == 16'h0)) m_unl = 0;
      end else if (dbg_key_valid && !scan_mode) begin
        if (dbg_key == KEY) m_unl = 1;
        else begin
          m_fails++;
          if (m_fails >= 3) m_out = 1; else m_wait = 16;
        end
      end
    end
    @(posedge clk); #1;
    o_rv = rsp_valid; o_err = rsp_err; o_rd = rsp_rdata;
    chk("rsp_valid", rsp_valid, nv);
    chk("rsp_err", rsp_err, ne);
    chk("rsp_rdata", rsp_rdata, nd);
    chk("dbg_unlocked", dbg_unlocked, m_unl);
    chk("dbg_lockout", dbg_lockout, m_out);
    chk("reg_q", reg_q, pack_regs());
    chk("lock_q", lock_q, pack_locks());
  endtask

  task automatic set_req(input int i, input bit v, input logic [1:0] op,
                         input logic [AW-1:0] addr, input logic [15:0] data);
    req_valid[i]          = v;
    req_op[2*i +: 2]      = op;
    req_addr[AW*i +: AW]  = addr;
    req_wdata[16*i +: 16] = data;
  endtask

  task automatic do_op(input int i, input logic [1:0] op,
                       input logic [AW-1:0] addr, input logic [15:0] data);
    set_req(i, 1'b1, op, addr, data);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] k);
    dbg_key_valid = 1'b1; dbg_key = k;
    tick();
    dbg_key_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    scan_mode = 1'b0; dbg_key_valid = 1'b0; dbg_key = 16'h0;
    last_grant = '0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    chk("rst_rsp", o_rv, 2'b00);

    // basic write then read-back
    do_op(0, 2'd1, 3'd2, 16'h1234);
    chk("wr1_vld", o_rv, 2'b01);
    chk("wr1_err", o_err, 1'b0);
    do_op(0, 2'd0, 3'd2, 16'h0);
    chk("rd1_data", o_rd, 16'h1234);

    // lock enforcement
    do_op(0, 2'd2, 3'd2, 16'h0);
    chk("lock_err", o_err, 1'b0);
    do_op(0, 2'd1, 3'd2, 16'hBEEF);
    chk("wrlk_err", o_err, 1'b1);
    chk("wrlk_reg", reg_q[32 +: 16], 16'h1234);
    chk("wrlk_bit", lock_q[2], 1'b1);
    do_op(0, 2'd2, 3'd2, 16'h0);
    chk("relock_err", o_err, 1'b0);
    do_op(1, 2'd3, 3'd5, 16'hFFFF);
    chk("rsv_err", o_err, 1'b1);

    // scan mode defeats an active unlock
    strobe(KEY);
    chk("unl_on", dbg_unlocked, 1'b1);
    scan_mode = 1'b1;
    do_op(1, 2'd1, 3'd2, 16'hDEAD);
    chk("scan_err", o_err, 1'b1);
    chk("scan_reg", reg_q[32 +: 16], 16'h1234);
    chk("scan_unl", dbg_unlocked, 1'b0);
    strobe(KEY);
    chk("scan_key", dbg_unlocked, 1'b0);
    scan_mode = 1'b0;

    // write alongside the key strobe is still rejected
    set_req(1, 1'b1, 2'd1, 3'd2, 16'h7777);
    strobe(KEY);
    req_valid[1] = 1'b0;
    chk("samecyc_err", o_err, 1'b1);
    chk("samecyc_unl", dbg_unlocked, 1'b1);
    do_op(0, 2'd1, 3'd2, 16'h5555);
    chk("dbgwr_err", o_err, 1'b0);
    chk("dbgwr_reg", reg_q[32 +: 16], 16'h5555);
    strobe(16'h0000);
    chk("relock_unl", dbg_unlocked, 1'b0);
    do_op(0, 2'd1, 3'd2, 16'h6666);
    chk("relock_wr", o_err, 1'b1);

    // three wrong keys, with strobes during each backoff ignored
    for (int n = 0; n < 3; n++) begin
      strobe(16'h1111);
      chk("lockout_step", dbg_lockout, (n == 2));
      if (n < 2) begin
        for (int c = 0; c < 20; c++) begin
          if (c == 3) begin dbg_key_valid = 1'b1; dbg_key = 16'h2222; end
          if (c == 10) begin dbg_key_valid = 1'b1; dbg_key = KEY; end
          tick();
          dbg_key_valid = 1'b0;
          if (c == 10) chk("bo_ignored", dbg_unlocked, 1'b0);
        end
      end
    end
    strobe(KEY);
    chk("lockout_key", dbg_unlocked, 1'b0);
    chk("lockout_hold", dbg_lockout, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_lockout", dbg_lockout, 1'b0);
    chk("rst_lockq", lock_q, 8'h00);

    // fairness with both requesters continuously valid
    set_req(0, 1'b1, 2'd0, 3'd0, 16'h0);
    set_req(1, 1'b1, 2'd0, 3'd1, 16'h0);
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("fair", last_grant, (c % 2 == 0) ? 2'b01 : 2'b10);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_rsp", o_rv, 2'b00);
    tick();
    chk("mid_rst_ptr", last_grant, 2'b01);
    req_valid = '0;
    tick();

    // random traffic
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || last_grant[i])
          set_req(i, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                  AW'($urandom_range(0, NREG - 1)), 16'($urandom));
      scan_mode     = ($urandom_range(0, 9) == 0);
      dbg_key_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 2))
        0: dbg_key = KEY;
        1: dbg_key = 16'h0000;
        default: dbg_key = 16'($urandom);
      endcase
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
